uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one UART transmitter among NUM_REQ byte-stream requesters. Each grant is held for a whole message, up to MAX_BURST bytes, so frames from different sources never interleave on the serial line. The block sits between the requester logic and the single `uart_tx` instance. It drives the transmitter's start/data inputs and paces them from its busy output.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 148 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width default and the tx scheduler state encoding.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        HOLD,
        START,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching upward from ptr, with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       gnt_any
);

    localparam int IDW = $clog2(NUM_REQ);

    int idx;

    // Scan from the farthest offset down so the closest requester to ptr is written last and wins.
    always_comb begin
        // NOTE: every target gets a default first so no path through the block infers a latch.
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte streams; a grant is held for a whole
// message (up to MAX_BURST bytes) so frames from different sources never interleave.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                          sys_clk,
    input  logic                          sreset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int HCW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    sched_state_t          state, state_d;
    logic [IDW-1:0]        rr_ptr, rr_ptr_d;
    logic [BCW-1:0]        burst_cnt, burst_cnt_d;
    logic [HCW-1:0]        hold_cnt, hold_cnt_d;
    logic                  last_q, last_d;
    logic [NUM_REQ-1:0]    req_ready_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic                  tx_start_d, grant_valid_d, timeout_err_d;
    logic [IDW-1:0]        grant_id_d;
    logic [IDW-1:0]        arb_id;
    logic                  arb_any;
    logic                  rel_grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        burst_cnt_d   = burst_cnt;
        hold_cnt_d    = '0;
        last_d        = last_q;
        req_ready_d   = '0;
        tx_data_d     = tx_data;
        tx_start_d    = tx_start;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
        timeout_err_d = 1'b0;
        rel_grant     = 1'b0;

        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d    = arb_id;
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = ACCEPT;
                end
            end
            // First ACCEPT cycle raises the registered ready; the next one is the handshake edge.
            ACCEPT: begin
                if (req_ready == '0) begin
                    if (req_valid[grant_id]) req_ready_d = NUM_REQ'(1) << grant_id;
                    else                     state_d     = HOLD;
                end else if (req_valid[grant_id]) begin
                    tx_data_d   = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
                    last_d      = req_last[grant_id];
                    burst_cnt_d = burst_cnt + BCW'(1);
                    tx_start_d  = 1'b1;
                    state_d     = START;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (req_valid[grant_id]) begin
                    state_d = ACCEPT;
                end else if (hold_cnt == HCW'(HOLD_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    rel_grant     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + HCW'(1);
                end
            end
            START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (last_q || burst_cnt == BCW'(MAX_BURST)) rel_grant = 1'b1;
                    else                                        state_d   = ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel_grant) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            state_d       = IDLE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sreset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            hold_cnt    <= '0;
            last_q      <= 1'b0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            burst_cnt   <= burst_cnt_d;
            hold_cnt    <= hold_cnt_d;
            last_q      <= last_d;
            req_ready   <= req_ready_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues and a simple transmitter model
// drive the block; expected byte orders and cycle timings are written out by hand.
module tb_uart_tx_scheduler;

    localparam int NR        = 4;
    localparam int DW        = 8;
    localparam int FRAME_LEN = 3;

    logic             sys_clk;
    logic             sreset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic             timeout_err;

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (4),
        .HOLD_TIMEOUT (8)
    ) dut (
        .sys_clk     (sys_clk),
        .sreset      (sreset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  mem [NR][16];
    int          rd_ptr [NR];
    int          wr_cnt [NR];
    int          busy_delay = 1;
    int          busy_age   = 0;
    int          start_age  = 0;
    logic [7:0]  sent_q [$];
    logic [7:0]  exp_q  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rd_ptr[i] < wr_cnt[i]) begin
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = mem[i][rd_ptr[i]][7:0];
                req_last[i]            = mem[i][rd_ptr[i]][8];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        mem[r][wr_cnt[r]] = {l, d};
        wr_cnt[r]++;
        drive();
    endtask

    // One clock: handshakes are sampled mid-cycle, then queues and the transmitter advance after the edge.
    task automatic tick();
        logic [NR-1:0] hs;
        @(negedge sys_clk);
        hs = req_valid & req_ready;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < NR; i++) if (hs[i]) rd_ptr[i]++;
        if (tx_busy) begin
            busy_age++;
            if (busy_age >= FRAME_LEN) tx_busy = 1'b0;
        end else if (tx_start) begin
            start_age++;
            if (start_age >= busy_delay) begin
                tx_busy   = 1'b1;
                busy_age  = 0;
                start_age = 0;
                sent_q.push_back(tx_data);
            end
        end else begin
            start_age = 0;
        end
        drive();
    endtask

    task automatic reset_all();
        sreset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rd_ptr[i] = 0;
            wr_cnt[i] = 0;
        end
        tx_busy    = 1'b0;
        busy_age   = 0;
        start_age  = 0;
        busy_delay = 1;
        drive();
        tick();
        sreset = 1'b0;
        sent_q.delete();
    endtask

    function automatic logic all_done();
        logic d;
        d = !grant_valid && !tx_busy;
        for (int i = 0; i < NR; i++) if (rd_ptr[i] != wr_cnt[i]) d = 1'b0;
        return d;
    endfunction

    task automatic run_until_done(input string tag);
        for (int n = 0; n < 300 && !all_done(); n++) tick();
        check({tag, "_done"}, all_done(), 1);
    endtask

    task automatic check_sent(input string tag);
        check({tag, "_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sreset  = 1'b1;
        tx_busy = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rd_ptr[i] = 0;
            wr_cnt[i] = 0;
        end
        drive();
        tick();
        check("rst_req_ready",   req_ready,   0);
        check("rst_tx_data",     tx_data,     0);
        check("rst_tx_start",    tx_start,    0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id",    grant_id,    0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rr_ptr",      dut.rr_ptr,  0);

        // Single requester, best-case latency.
        reset_all();
        load(0, 8'hA5, 1'b1);
        tick();
        check("t1_e0_grant_valid", grant_valid, 1);
        check("t1_e0_grant_id",    grant_id,    0);
        check("t1_e0_tx_start",    tx_start,    0);
        tick();
        check("t1_e1_req_ready",   req_ready,   4'b0001);
        tick();
        check("t1_e2_tx_start",    tx_start,    1);
        check("t1_e2_tx_data",     tx_data,     8'hA5);
        check("t1_e2_req_ready",   req_ready,   0);
        repeat (3) tick();
        check("t1_e5_grant_held",  grant_valid, 1);
        tick();
        check("t1_e6_released",    grant_valid, 0);
        check("t1_rr_ptr",         dut.rr_ptr,  1);

        // Contention between req 1 and req 3.
        reset_all();
        load(1, 8'h11, 1'b0);
        load(1, 8'h12, 1'b1);
        load(3, 8'h31, 1'b0);
        load(3, 8'h32, 1'b1);
        run_until_done("t2");
        exp_q = '{8'h11, 8'h12, 8'h31, 8'h32};
        check_sent("t2");
        check("t2_rr_ptr", dut.rr_ptr, 0);

        // Burst cap of 4 forces rotation to req 0 mid-message.
        reset_all();
        for (int b = 1; b <= 6; b++) load(2, 8'(8'h20 + b), (b == 6));
        tick();
        check("t3_first_grant", grant_id, 2);
        load(0, 8'h01, 1'b0);
        load(0, 8'h02, 1'b1);
        run_until_done("t3");
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h01, 8'h02, 8'h25, 8'h26};
        check_sent("t3");

        // Hold timeout: req 1 stalls after one byte without last; req 2 waits.
        reset_all();
        load(1, 8'h41, 1'b0);
        load(2, 8'h51, 1'b1);
        for (int n = 0; n < 50 && !(sent_q.size() == 1 && !tx_busy); n++) tick();
        check("t4_first_byte_done", (sent_q.size() == 1 && !tx_busy), 1);
        // busy falls at f; DRAIN->ACCEPT at f+1, ACCEPT->HOLD at f+2, timeout at f+10.
        repeat (9) tick();
        check("t4_f9_timeout_err", timeout_err, 0);
        check("t4_f9_grant_valid", grant_valid, 1);
        tick();
        check("t4_f10_timeout_err", timeout_err, 1);
        check("t4_f10_grant_valid", grant_valid, 0);
        tick();
        check("t4_f11_timeout_err", timeout_err, 0);
        check("t4_f11_grant_valid", grant_valid, 1);
        check("t4_f11_grant_id",    grant_id,    2);
        run_until_done("t4");
        exp_q = '{8'h41, 8'h51};
        check_sent("t4");

        // Reset asserted while in START.
        reset_all();
        busy_delay = 5;
        load(0, 8'h77, 1'b1);
        repeat (3) tick();
        check("t5_in_start", tx_start, 1);
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        check("t5_req_ready",   req_ready,   0);
        check("t5_tx_data",     tx_data,     0);
        check("t5_tx_start",    tx_start,    0);
        check("t5_grant_valid", grant_valid, 0);
        check("t5_grant_id",    grant_id,    0);
        check("t5_timeout_err", timeout_err, 0);
        load(0, 8'h78, 1'b1);
        tick();
        check("t5_regrant_no_ready", req_ready,   0);
        check("t5_regrant_valid",    grant_valid, 1);
        tick();
        check("t5_ready_after_idle", req_ready,   4'b0001);
        run_until_done("t5");
        exp_q = '{8'h78};
        check_sent("t5");

        // Slow transmitter: busy rises 5 cycles after tx_start.
        reset_all();
        busy_delay = 5;
        load(3, 8'h61, 1'b0);
        load(3, 8'h62, 1'b1);
        for (int n = 0; n < 20 && !tx_start; n++) tick();
        check("t6_tx_start_seen", tx_start, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t6_s%0d_tx_start", k),  tx_start,  1);
            check($sformatf("t6_s%0d_tx_data", k),   tx_data,   8'h61);
            check($sformatf("t6_s%0d_req_ready", k), req_ready, 0);
        end
        tick();
        check("t6_s5_tx_start_drop", tx_start, 0);
        run_until_done("t6");
        exp_q = '{8'h61, 8'h62};
        check_sent("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
